// File: rtl/cam_if_pkg.sv
// Shared definitions for the camera dozen path.
// Holds the dozen/byte widths, the serializer FSM state type, the class
// encoding carried alongside each dozen, and a malformed-flag helper.
package cam_if_pkg;

  localparam int unsigned DOZEN_W = 12;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned NIB_W   = 4;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_NIB,
    S_TAIL
  } ser_state_e;

  localparam logic CLS_PIXEL = 1'b0;
  localparam logic CLS_META  = 1'b1;

  // A dozen must carry exactly one of the two class flags.
  function automatic logic is_malformed(input logic meta_flag, input logic pix_flag);
    return meta_flag == pix_flag;
  endfunction

endpackage

// File: rtl/dozen_byte_serializer.sv
// Repacks 12-bit dozens into an 8-bit byte stream. Two dozens of the same
// class form three bytes; a class change or a flush closes the run, padding
// an odd trailing nibble and flagging the final byte with byte_last.
// Malformed dozens (both or neither class flag) are consumed, dropped and
// counted in a saturating error counter.
//
// Ports:
//   clk, reset_n           clock, synchronous active-low reset
//   dozen_in, *_in_flag    dozen and its class flags
//   dozen_valid/ready      input handshake
//   flush                  single-cycle request to close the current run
//   byte_out, byte_valid   registered output byte and its valid
//   byte_ready             downstream accept
//   byte_metadata          byte belongs to a metadata run
//   byte_last              final byte of a run
//   err_count              saturating count of dropped malformed dozens
module dozen_byte_serializer
  import cam_if_pkg::*;
#(
  parameter logic [NIB_W-1:0] PAD_NIBBLE = 4'h0,
  parameter int unsigned      ERR_W      = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [DOZEN_W-1:0] dozen_in,
  input  logic               metadata_in_flag,
  input  logic               pixel_data_in_flag,
  input  logic               dozen_valid,
  output logic               dozen_ready,
  input  logic               flush,
  output logic [BYTE_W-1:0]  byte_out,
  output logic               byte_valid,
  input  logic               byte_ready,
  output logic               byte_metadata,
  output logic               byte_last,
  output logic [ERR_W-1:0]   err_count
);

  ser_state_e        state_q;
  logic [NIB_W-1:0]  nib_q;
  logic              cls_q;
  logic [BYTE_W-1:0] tail_q;
  logic              flush_pending_q;
  logic [BYTE_W-1:0] byte_q;
  logic              byte_valid_q;
  logic              byte_meta_q;
  logic              byte_last_q;
  logic [ERR_W-1:0]  err_q;

  logic out_free;
  logic malformed;
  logic cls_in;
  logic cls_match;
  logic dozen_fire;
  logic accept;
  logic drop;
  logic close_req;

  assign out_free   = !byte_valid_q || byte_ready;
  assign malformed  = is_malformed(metadata_in_flag, pixel_data_in_flag);
  assign cls_in     = metadata_in_flag ? CLS_META : CLS_PIXEL;
  // Malformed dozens never count as a class change; they are simply dropped.
  assign cls_match  = malformed || (cls_in == cls_q);
  assign dozen_fire = dozen_valid && dozen_ready;
  assign accept     = dozen_fire && !malformed;
  assign drop       = dozen_fire && malformed;
  assign close_req  = flush || flush_pending_q ||
                      (dozen_valid && !malformed && (cls_in != cls_q));

  always_comb begin
    dozen_ready = 1'b0;
    unique case (state_q)
      S_EMPTY: dozen_ready = out_free;
      S_NIB:   dozen_ready = out_free && !flush_pending_q && !flush && cls_match;
      S_TAIL:  dozen_ready = 1'b0;
      default: dozen_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= S_EMPTY;
      nib_q           <= '0;
      cls_q           <= CLS_PIXEL;
      tail_q          <= '0;
      flush_pending_q <= 1'b0;
      byte_q          <= '0;
      byte_valid_q    <= 1'b0;
      byte_meta_q     <= 1'b0;
      byte_last_q     <= 1'b0;
      err_q           <= '0;
    end else begin
      if (drop && (err_q != '1)) begin
        err_q <= err_q + {{(ERR_W-1){1'b0}}, 1'b1};
      end

      // Byte taken (or slot empty): clear valid unless a new byte loads below.
      if (out_free) begin
        byte_valid_q <= 1'b0;
      end

      unique case (state_q)
        S_EMPTY: begin
          if (accept) begin
            byte_q       <= dozen_in[11:4];
            byte_valid_q <= 1'b1;
            byte_meta_q  <= cls_in;
            byte_last_q  <= 1'b0;
            nib_q        <= dozen_in[3:0];
            cls_q        <= cls_in;
            state_q      <= S_NIB;
            // A flush alongside the first dozen closes that new run.
            if (flush) begin
              flush_pending_q <= 1'b1;
            end
          end
        end
        S_NIB: begin
          if (accept) begin
            byte_q       <= {nib_q, dozen_in[11:8]};
            byte_valid_q <= 1'b1;
            byte_meta_q  <= cls_q;
            byte_last_q  <= 1'b0;
            tail_q       <= dozen_in[7:0];
            state_q      <= S_TAIL;
          end else if (out_free && close_req) begin
            byte_q          <= {nib_q, PAD_NIBBLE};
            byte_valid_q    <= 1'b1;
            byte_meta_q     <= cls_q;
            byte_last_q     <= 1'b1;
            flush_pending_q <= 1'b0;
            state_q         <= S_EMPTY;
          end else if (flush) begin
            flush_pending_q <= 1'b1;
          end
        end
        S_TAIL: begin
          if (out_free) begin
            byte_q          <= tail_q;
            byte_valid_q    <= 1'b1;
            byte_meta_q     <= cls_q;
            byte_last_q     <= flush_pending_q || flush;
            flush_pending_q <= 1'b0;
            state_q         <= S_EMPTY;
          end else if (flush) begin
            flush_pending_q <= 1'b1;
          end
        end
        default: state_q <= S_EMPTY;
      endcase
    end
  end

  assign byte_out      = byte_q;
  assign byte_valid    = byte_valid_q;
  assign byte_metadata = byte_meta_q;
  assign byte_last     = byte_last_q;
  assign err_count     = err_q;

endmodule

// File: tb/tb_dozen_byte_serializer.sv
module tb_dozen_byte_serializer;

  localparam int NRND = 1000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] dozen_in;
  logic        meta_f;
  logic        pix_f;
  logic        dozen_valid;
  logic        dozen_ready;
  logic        flush;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic        byte_metadata;
  logic        byte_last;
  logic [7:0]  err_count;

  logic dir_ready;
  logic rnd_mode;
  logic rnd_bit;
  assign byte_ready = rnd_mode ? rnd_bit : dir_ready;

  int checks = 0;
  int passes = 0;

  // Entries are {metadata, last, byte}.
  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  dozen_byte_serializer #(
    .PAD_NIBBLE(4'h0),
    .ERR_W     (8)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .dozen_in          (dozen_in),
    .metadata_in_flag  (meta_f),
    .pixel_data_in_flag(pix_f),
    .dozen_valid       (dozen_valid),
    .dozen_ready       (dozen_ready),
    .flush             (flush),
    .byte_out          (byte_out),
    .byte_valid        (byte_valid),
    .byte_ready        (byte_ready),
    .byte_metadata     (byte_metadata),
    .byte_last         (byte_last),
    .err_count         (err_count)
  );

  // Inputs change only just after posedge, so the negedge view equals the edge view.
  always @(negedge clk) begin
    if (reset_n && byte_valid && byte_ready) got_q.push_back({byte_metadata, byte_last, byte_out});
  end

  initial begin
    rnd_bit = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rnd_bit = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_dozen(input logic [11:0] d, input logic m, input logic p);
    int n;
    bit done;
    n = 0;
    done = 0;
    dozen_in = d;
    meta_f = m;
    pix_f = p;
    dozen_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (dozen_ready) done = 1;
      else begin
        n++;
        if (n > 2000) begin
          check("send_timeout", {31'd0, dozen_ready}, 32'd1);
          dozen_valid = 1'b0;
          step(1);
          return;
        end
      end
    end
    @(posedge clk);
    #1;
    dozen_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step(1);
    flush = 1'b0;
  endtask

  task automatic expect_byte(input logic m, input logic l, input logic [7:0] b);
    exp_q.push_back({m, l, b});
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check(tag, {22'd0, got_q[i]}, {22'd0, exp_q[i]});
    end
    got_q.delete();
    exp_q.delete();
  endtask

  logic [11:0] rd[NRND];
  logic        rc[NRND];

  initial begin
    logic       cls;
    logic [3:0] nibs[$];
    logic       padded;
    int         j;
    int         k;

    reset_n = 1'b0;
    dir_ready = 1'b1;
    rnd_mode = 1'b0;
    dozen_valid = 1'b0;
    dozen_in = '0;
    meta_f = 1'b0;
    pix_f = 1'b0;
    flush = 1'b0;
    padded = 1'b0;
    step(2);

    // Reset state
    check("rst_valid", {31'd0, byte_valid}, 32'd0);
    check("rst_byte", {24'd0, byte_out}, 32'd0);
    check("rst_meta", {31'd0, byte_metadata}, 32'd0);
    check("rst_last", {31'd0, byte_last}, 32'd0);
    check("rst_err", {24'd0, err_count}, 32'd0);
    reset_n = 1'b1;
    step(1);
    check("idle_ready", {31'd0, dozen_ready}, 32'd1);

    // Two pixel dozens -> three bytes, one-cycle latency, no ready in tail.
    send_dozen(12'hABC, 1'b0, 1'b1);
    check("lat_valid", {31'd0, byte_valid}, 32'd1);
    check("lat_byte", {24'd0, byte_out}, 32'h000000AB);
    send_dozen(12'h123, 1'b0, 1'b1);
    check("tail_ready", {31'd0, dozen_ready}, 32'd0);
    check("mid_byte", {24'd0, byte_out}, 32'h000000C1);
    step(1);
    check("tail_byte", {24'd0, byte_out}, 32'h00000023);
    step(3);
    expect_byte(0, 0, 8'hAB);
    expect_byte(0, 0, 8'hC1);
    expect_byte(0, 0, 8'h23);
    compare_stream("pair");

    // Class change pads the pixel run; metadata run closed by flush.
    send_dozen(12'hABC, 1'b0, 1'b1);
    send_dozen(12'h456, 1'b1, 1'b0);
    pulse_flush();
    step(3);
    expect_byte(0, 0, 8'hAB);
    expect_byte(0, 1, 8'hC0);
    expect_byte(1, 0, 8'h45);
    expect_byte(1, 1, 8'h60);
    compare_stream("clschg");

    // Flush with ready high.
    send_dozen(12'hF0F, 1'b0, 1'b1);
    pulse_flush();
    step(3);
    expect_byte(0, 0, 8'hF0);
    expect_byte(0, 1, 8'hF0);
    compare_stream("flush");

    // Flush under backpressure is held pending.
    dir_ready = 1'b0;
    send_dozen(12'hF0F, 1'b0, 1'b1);
    pulse_flush();
    step(3);
    check("bp_hold_byte", {24'd0, byte_out}, 32'h000000F0);
    check("bp_hold_valid", {31'd0, byte_valid}, 32'd1);
    check("bp_hold_last", {31'd0, byte_last}, 32'd0);
    check("bp_no_ready", {31'd0, dozen_ready}, 32'd0);
    dir_ready = 1'b1;
    step(4);
    expect_byte(0, 0, 8'hF0);
    expect_byte(0, 1, 8'hF0);
    compare_stream("flush_bp");

    // Malformed dozens: dropped, counted, saturating.
    for (int i = 0; i < 300; i++) begin
      send_dozen(12'($urandom), (i % 2) == 0, (i % 2) == 0);
      if (i == 4) check("err_5", {24'd0, err_count}, 32'd5);
    end
    step(3);
    check("err_sat", {24'd0, err_count}, 32'h000000FF);
    check("malf_no_bytes", got_q.size(), 32'd0);
    check("malf_valid", {31'd0, byte_valid}, 32'd0);
    check("malf_ready", {31'd0, dozen_ready}, 32'd1);

    // Random stream with random backpressure, reference built per run.
    cls = 1'b0;
    for (int i = 0; i < NRND; i++) begin
      if ($urandom_range(0, 7) == 0) cls = ~cls;
      rd[i] = 12'($urandom);
      rc[i] = cls;
    end
    j = 0;
    while (j < NRND) begin
      k = j;
      nibs.delete();
      while (k < NRND && rc[k] == rc[j]) begin
        nibs.push_back(rd[k][11:8]);
        nibs.push_back(rd[k][7:4]);
        nibs.push_back(rd[k][3:0]);
        k++;
      end
      padded = (nibs.size() % 2) != 0;
      if (padded) nibs.push_back(4'h0);
      for (int b = 0; b < nibs.size() / 2; b++) begin
        expect_byte(rc[j], padded && (b == nibs.size() / 2 - 1), {nibs[2*b], nibs[2*b+1]});
      end
      j = k;
    end
    rnd_mode = 1'b1;
    for (int i = 0; i < NRND; i++) begin
      k = $urandom_range(0, 2);
      if (k > 0) step(k);
      send_dozen(rd[i], rc[i], !rc[i]);
    end
    if (padded) pulse_flush();
    step(20);
    rnd_mode = 1'b0;
    dir_ready = 1'b1;
    step(5);
    compare_stream("random");

    // Reset while a tail byte is pending.
    send_dozen(12'h111, 1'b0, 1'b1);
    send_dozen(12'h222, 1'b0, 1'b1);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    check("rst2_valid", {31'd0, byte_valid}, 32'd0);
    check("rst2_err", {24'd0, err_count}, 32'd0);
    got_q.delete();
    send_dozen(12'h789, 1'b0, 1'b1);
    check("rst2_first", {24'd0, byte_out}, 32'h00000078);
    pulse_flush();
    step(3);
    expect_byte(0, 0, 8'h78);
    expect_byte(0, 1, 8'h90);
    compare_stream("post_rst");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
